// File: rtl/inst_hw_stream.sv
// Fetch-side halfword streamer: one outstanding 32-bit imem read, split into a DEPTH-entry halfword buffer.
// Branch-to-first-halfword is 3 cycles on a zero-wait memory; fetch stalls when fewer than 2 slots are free.
module inst_hw_stream #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [15:0]       inst_hw,
    output logic              hw_valid,
    input  logic              hw_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t            r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              r_skip;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [15:0]       r_buf [DEPTH];

    logic          w_accept;
    logic          w_push2;
    logic          w_push1;
    logic          w_pop;
    logic          w_issue;
    logic [CW-1:0] w_npush;
    logic [PW-1:0] w_wr_ptr1;
    logic          w_unused_bit0;

    // A redirect kills any same-cycle return, pop and issue.
    assign w_accept  = (r_state == S_WAIT) && imem_rvalid && !branch_valid;
    assign w_push2   = w_accept && !r_skip;
    assign w_push1   = w_accept && r_skip;
    assign w_pop     = hw_valid && hw_ready && !branch_valid;
    assign w_issue   = (r_state == S_IDLE) && !branch_valid && (r_count <= CW'(DEPTH - 2));
    assign w_npush   = w_push2 ? CW'(2) : (w_push1 ? CW'(1) : CW'(0));
    assign w_wr_ptr1 = r_wr_ptr + PW'(1);
    assign w_unused_bit0 = branch_addr[0];

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign hw_valid  = (r_count != '0);
    assign inst_hw   = hw_valid ? r_buf[r_rd_ptr] : 16'h0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_addr       <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_skip       <= 1'b0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_addr;
                    end
                end
                S_WAIT: begin
                    // The request stays up after a redirect; its answer must still be drained.
                    if (branch_valid) begin
                        r_state <= S_DROP;
                    end else if (imem_rvalid) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (branch_valid) begin
                r_count      <= '0;
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                r_fetch_addr <= {branch_addr[ADDR_W-1:2], 2'b00};
                r_skip       <= branch_addr[1];
            end else begin
                if (w_accept) begin
                    r_fetch_addr <= r_fetch_addr + ADDR_W'(4);
                    r_skip       <= 1'b0;
                end
                if (w_push2) begin
                    r_wr_ptr <= r_wr_ptr + PW'(2);
                end else if (w_push1) begin
                    r_wr_ptr <= w_wr_ptr1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + w_npush - CW'(w_pop);
            end
        end
    end

    // Buffer storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_push2) begin
            r_buf[r_wr_ptr]  <= imem_rdata[15:0];
            r_buf[w_wr_ptr1] <= imem_rdata[31:16];
        end else if (w_push1) begin
            r_buf[r_wr_ptr]  <= imem_rdata[31:16];
        end
    end
endmodule

// File: tb/tb_inst_hw_stream.sv
// Directed bench for inst_hw_stream: background memory responder plus request/halfword logs.
module tb_inst_hw_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_valid;
    logic [31:0] branch_addr;
    logic [15:0] inst_hw;
    logic        hw_valid;
    logic        hw_ready;

    int tests = 0;
    int fails = 0;

    bit          mem_en;
    int          mem_delay;
    int          wcnt = 0;
    logic        a_rvalid = 1'b0;
    logic [31:0] a_rdata = '0;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        prev_req = 1'b0;
    logic [31:0] req_q[$];
    logic [15:0] hw_q[$];

    always #5 clk = ~clk;

    assign imem_rvalid = mem_en ? a_rvalid : m_rvalid;
    assign imem_rdata  = mem_en ? a_rdata  : m_rdata;

    inst_hw_stream #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .branch_valid(branch_valid), .branch_addr(branch_addr),
        .inst_hw(inst_hw), .hw_valid(hw_valid), .hw_ready(hw_ready)
    );

    function automatic logic [15:0] hwv(input logic [31:0] a);
        return 16'hA000 | {4'h0, a[11:0]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hB510_F000;
        return {hwv(a + 32'd2), hwv(a)};
    endfunction

    // Memory answers mem_delay cycles after it sees a request, one-cycle rvalid pulse.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            a_rvalid = 1'b0;
            wcnt     = 0;
        end else if (a_rvalid) begin
            a_rvalid = 1'b0;
        end else if (imem_req) begin
            if (wcnt >= mem_delay) begin
                a_rvalid = 1'b1;
                a_rdata  = mem_word(imem_addr);
                wcnt     = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (imem_req && !prev_req) req_q.push_back(imem_addr);
            if (hw_valid && hw_ready && !branch_valid) hw_q.push_back(inst_hw);
        end
        prev_req = imem_req;
    end

    function automatic logic [31:0] qr(input int i);
        if (i < req_q.size()) return req_q[i];
        return 'x;
    endfunction

    function automatic logic [31:0] qh(input int i);
        if (i < hw_q.size()) return {16'h0, hw_q[i]};
        return 'x;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        req_q.delete();
        hw_q.delete();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (imem_req !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk(tag, {31'h0, imem_req}, 32'h1);
    endtask

    task automatic branch_to(input logic [31:0] a);
        branch_valid = 1'b1;
        branch_addr  = a;
        step();
        branch_valid = 1'b0;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; hw_ready = 1'b1; branch_valid = 1'b0; branch_addr = '0;
        m_rvalid = 1'b0; m_rdata = '0; mem_en = 1'b1; mem_delay = 0;

        // 1: reset state, then streaming with a zero-wait memory
        step(2);
        chk("rst_req",  {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_vld",  {31'h0, hw_valid}, 32'h0);
        chk("rst_hw",   {16'h0, inst_hw}, 32'h0);
        rst = 1'b1;
        clear_logs();
        step();
        chk("t1_req_lat", {31'h0, imem_req}, 32'h1);
        step(5);
        chk("t1_req0", qr(0), 32'h0);
        chk("t1_req1", qr(1), 32'h4);
        chk("t1_hw0",  qh(0), 32'hF000);
        chk("t1_hw1",  qh(1), 32'hB510);
        chk("t1_hw2",  qh(2), 32'hA004);

        // 2: consumer stalled -> buffer fills to 4 and fetch stops
        rst = 1'b0; hw_ready = 1'b0;
        step(2);
        rst = 1'b1;
        clear_logs();
        step(10);
        chk("t2_nreq", req_q.size(), 32'd2);
        chk("t2_req1", qr(1), 32'h4);
        chk("t2_idle", {31'h0, imem_req}, 32'h0);
        chk("t2_head", {16'h0, inst_hw}, 32'hF000);
        hw_ready = 1'b1;
        step(8);
        chk("t2_hw0",  qh(0), 32'hF000);
        chk("t2_hw1",  qh(1), 32'hB510);
        chk("t2_hw2",  qh(2), 32'hA004);
        chk("t2_hw3",  qh(3), 32'hA006);
        chk("t2_req2", qr(2), 32'h8);

        // 3: branch to a mid-word target
        branch_to(32'h0000_0102);
        chk("t3_flush", {31'h0, hw_valid}, 32'h0);
        step(8);
        chk("t3_req0", qr(0), 32'h100);
        chk("t3_hw0",  qh(0), 32'hA102);
        chk("t3_hw1",  qh(1), 32'hA104);
        chk("t3_req1", qr(1), 32'h104);

        // 4: branch while waiting on a slow memory
        mem_delay = 3;
        wait_req("t4_wait");
        branch_to(32'h0000_0200);
        chk("t4_hold",  {31'h0, imem_req}, 32'h1);
        chk("t4_flush", {31'h0, hw_valid}, 32'h0);
        step(20);
        chk("t4_req0", qr(0), 32'h200);
        chk("t4_hw0",  qh(0), 32'hA200);
        chk("t4_hw1",  qh(1), 32'hA202);

        // 5a: branch coincident with a pop at count=3
        mem_delay = 0; hw_ready = 1'b0;
        branch_to(32'h0000_0300);
        step(12);
        chk("t5_full_idle", {31'h0, imem_req}, 32'h0);
        chk("t5_head", {16'h0, inst_hw}, 32'hA300);
        hw_ready = 1'b1;
        step();
        chk("t5_head2", {16'h0, inst_hw}, 32'hA302);
        chk("t5_noreq", {31'h0, imem_req}, 32'h0);
        branch_to(32'h0000_0400);
        hw_ready = 1'b0;
        chk("t5_vld0", {31'h0, hw_valid}, 32'h0);
        chk("t5_hw0",  {16'h0, inst_hw}, 32'h0);
        hw_ready = 1'b1;
        step(10);
        chk("t5_s0", qh(0), 32'hA400);
        chk("t5_s1", qh(1), 32'hA402);
        chk("t5_s2", qh(2), 32'hA404);

        // 5b: branch in the same cycle as rvalid in WAIT
        wait_req("t5b_wait");
        branch_to(32'h0000_0600);
        chk("t5b_hold",  {31'h0, imem_req}, 32'h1);
        chk("t5b_flush", {31'h0, hw_valid}, 32'h0);
        step(12);
        chk("t5b_req0", qr(0), 32'h600);
        chk("t5b_hw0",  qh(0), 32'hA600);
        chk("t5b_hw1",  qh(1), 32'hA602);

        // 6: address wrap, then reset mid-request with a late rvalid
        mem_en = 1'b0; rst = 1'b0;
        step(2);
        rst = 1'b1;
        clear_logs();
        branch_to(32'hFFFF_FFFC);
        step();
        chk("t6_req",  {31'h0, imem_req}, 32'h1);
        chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        step();
        m_rvalid = 1'b0;
        chk("t6_vld", {31'h0, hw_valid}, 32'h1);
        chk("t6_lo",  {16'h0, inst_hw}, 32'h5678);
        step();
        chk("t6_wrap_req",  {31'h0, imem_req}, 32'h1);
        chk("t6_wrap_addr", imem_addr, 32'h0);
        chk("t6_hi", {16'h0, inst_hw}, 32'h1234);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_rst_req", {31'h0, imem_req}, 32'h0);
        chk("t6_rst_vld", {31'h0, hw_valid}, 32'h0);
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        step();
        m_rvalid = 1'b0;
        chk("t6_stale_vld", {31'h0, hw_valid}, 32'h0);
        chk("t6_new_req",   {31'h0, imem_req}, 32'h1);
        chk("t6_new_addr",  imem_addr, 32'h0);
        step(3);
        chk("t6_still_empty", {31'h0, hw_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
